// File: rtl/cc_mux_pkg.sv
// Shared definitions for the cc_muxx_rr channel multiplexer: mode codes,
// output-stage state encoding and an index-width helper.
package cc_mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } outState_e;

  // Bits needed to index 'value' items; callers pass value >= 2.
  function automatic int clog2Int(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/cc_rr_arbiter.sv
// Combinational round-robin arbiter: searches ptr+1, ptr+2, ... modulo NUM_CH,
// so the channel at ptr itself has the lowest priority.
module cc_rr_arbiter #(
  parameter int NUM_CH = 8,
  parameter int IDX_W  = 3
) (
  input  logic [NUM_CH-1:0] reqVec,
  input  logic [IDX_W-1:0]  rrPtr,
  output logic [NUM_CH-1:0] grantOneHot,
  output logic [IDX_W-1:0]  grantIdx,
  output logic              grantValid
);

  int cand;

  always_comb begin
    grantOneHot = '0;
    grantIdx    = '0;
    grantValid  = 1'b0;
    cand        = 0;
    for (int i = 1; i <= NUM_CH; i++) begin
      cand = (int'(rrPtr) + i) % NUM_CH;
      if (!grantValid && reqVec[cand]) begin
        grantValid        = 1'b1;
        grantIdx          = IDX_W'(cand);
        grantOneHot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cc_muxx_rr.sv
// NUM_CH-way bus multiplexer with fixed or round-robin selection feeding a
// one-entry registered output stage with valid/ready on both sides.
module cc_muxx_rr
  import cc_mux_pkg::*;
#(
  parameter int NUM_CH                  = 8,
  parameter int DATAWIDTH_BUS           = 32,
  parameter int DATAWIDTH_MUX_SELECTION = 4
) (
  input  logic                                CC_MUX_CLOCK_50,
  input  logic                                CC_MUX_RESET_InLow,
  input  logic [NUM_CH*DATAWIDTH_BUS-1:0]     CC_MUX_data_InBUS,
  input  logic [NUM_CH-1:0]                   CC_MUX_valid_InBUS,
  output logic [NUM_CH-1:0]                   CC_MUX_ready_OutBUS,
  input  logic                                CC_MUX_mode_In,
  input  logic [DATAWIDTH_MUX_SELECTION-1:0]  CC_MUX_selection_InBUS,
  output logic [DATAWIDTH_BUS-1:0]            CC_MUX_data_OutBUS,
  output logic                                CC_MUX_valid_Out,
  input  logic                                CC_MUX_ready_In,
  output logic [DATAWIDTH_MUX_SELECTION-1:0]  CC_MUX_channel_OutBUS,
  output logic                                CC_MUX_state_OutDbg
);

  // Handshake: a word moves on a side in any cycle where both valid and ready
  // are high at the rising edge. Producers must not wait for ready to raise
  // valid; ready depends combinationally on valid, mode, selection, ready_In.

  localparam int DW    = DATAWIDTH_BUS;
  localparam int SW    = DATAWIDTH_MUX_SELECTION;
  localparam int PTR_W = clog2Int(NUM_CH);

  outState_e         outState;
  logic [PTR_W-1:0]  rrPtr;
  logic [PTR_W-1:0]  rrIdx;
  logic [NUM_CH-1:0] rrOneHot;
  logic              rrFound;

  logic [SW-1:0]     fixCand;
  logic [NUM_CH-1:0] fixOneHot;
  logic              fixFound;

  logic [SW-1:0]     grantIdx;
  logic              grantFound;
  logic              loadEn;
  logic [DW-1:0]     selData;

  cc_rr_arbiter #(
    .NUM_CH (NUM_CH),
    .IDX_W  (PTR_W)
  ) uArbiter (
    .reqVec      (CC_MUX_valid_InBUS),
    .rrPtr       (rrPtr),
    .grantOneHot (rrOneHot),
    .grantIdx    (rrIdx),
    .grantValid  (rrFound)
  );

  // Out-of-range selections fall back to channel 0 like the legacy mux.
  always_comb begin
    fixCand   = (int'(CC_MUX_selection_InBUS) < NUM_CH) ? CC_MUX_selection_InBUS : '0;
    fixOneHot = '0;
    fixFound  = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (fixCand == SW'(k) && CC_MUX_valid_InBUS[k]) begin
        fixOneHot[k] = 1'b1;
        fixFound     = 1'b1;
      end
    end
  end

  always_comb begin
    loadEn     = (outState == ST_EMPTY) || CC_MUX_ready_In;
    grantFound = (CC_MUX_mode_In == MODE_RR) ? rrFound : fixFound;
    grantIdx   = (CC_MUX_mode_In == MODE_RR) ? SW'(rrIdx) : fixCand;
    if (!loadEn) begin
      CC_MUX_ready_OutBUS = '0;
    end else if (CC_MUX_mode_In == MODE_RR) begin
      CC_MUX_ready_OutBUS = rrOneHot;
    end else begin
      CC_MUX_ready_OutBUS = fixOneHot;
    end
  end

  always_comb begin
    selData = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (grantIdx == SW'(k)) begin
        selData = CC_MUX_data_InBUS[k*DW +: DW];
      end
    end
  end

  // Output stage: reloads whenever empty or the consumer takes the held word,
  // so back-to-back words stream at one per cycle.
  always_ff @(posedge CC_MUX_CLOCK_50 or negedge CC_MUX_RESET_InLow) begin
    if (!CC_MUX_RESET_InLow) begin
      outState              <= ST_EMPTY;
      CC_MUX_data_OutBUS    <= '0;
      CC_MUX_channel_OutBUS <= '0;
      rrPtr                 <= PTR_W'(NUM_CH - 1);
    end else if (loadEn) begin
      if (grantFound) begin
        outState              <= ST_FULL;
        CC_MUX_data_OutBUS    <= selData;
        CC_MUX_channel_OutBUS <= grantIdx;
        if (CC_MUX_mode_In == MODE_RR) begin
          rrPtr <= rrIdx;
        end
      end else begin
        outState <= ST_EMPTY;
      end
    end
  end

  assign CC_MUX_valid_Out    = (outState == ST_FULL);
  assign CC_MUX_state_OutDbg = outState;

endmodule

// File: tb/tb_cc_muxx_rr.sv
// Bench for cc_muxx_rr: directed vector table, hand-written reset/stall
// sequences, and randomized traffic against a behavioural reference model.
module tb_cc_muxx_rr;

  localparam int NCH = 8;
  localparam int DW  = 32;
  localparam int SW  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NCH*DW-1:0] dataBus;
  logic [DW-1:0]     chData [NCH];
  logic [NCH-1:0]    validIn;
  logic [NCH-1:0]    readyOut;
  logic              modeIn;
  logic [SW-1:0]     selIn;
  logic [DW-1:0]     dataOut;
  logic              validOut;
  logic              readyIn;
  logic [SW-1:0]     chanOut;
  logic              stateDbg;

  int nTests = 0;
  int nFail  = 0;

  typedef struct {
    logic           mode;
    logic [SW-1:0]  sel;
    logic [NCH-1:0] valid;
    logic           rdy;
    logic [NCH-1:0] expReady;
    logic           expValid;
    logic [SW-1:0]  expChan;
    logic [DW-1:0]  expData;
  } vec_t;

  vec_t vecs[$];

  // Reference model state
  logic          mValid;
  logic [DW-1:0] mData;
  int            mChan;
  int            mPtr;

  cc_muxx_rr #(
    .NUM_CH                  (NCH),
    .DATAWIDTH_BUS           (DW),
    .DATAWIDTH_MUX_SELECTION (SW)
  ) dut (
    .CC_MUX_CLOCK_50        (clk),
    .CC_MUX_RESET_InLow     (rst_n),
    .CC_MUX_data_InBUS      (dataBus),
    .CC_MUX_valid_InBUS     (validIn),
    .CC_MUX_ready_OutBUS    (readyOut),
    .CC_MUX_mode_In         (modeIn),
    .CC_MUX_selection_InBUS (selIn),
    .CC_MUX_data_OutBUS     (dataOut),
    .CC_MUX_valid_Out       (validOut),
    .CC_MUX_ready_In        (readyIn),
    .CC_MUX_channel_OutBUS  (chanOut),
    .CC_MUX_state_OutDbg    (stateDbg)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int k = 0; k < NCH; k++) dataBus[k*DW +: DW] = chData[k];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] dirData(input int k);
    if (k == 0) return 32'h0000_0011;
    if (k == 3) return 32'hDEAD_BEEF;
    return 32'h1000_0000 + k;
  endfunction

  function automatic vec_t mk(input logic mode, input logic [SW-1:0] sel,
                              input logic [NCH-1:0] valid, input logic rdy,
                              input logic [NCH-1:0] er, input logic ev,
                              input int ec, input logic [DW-1:0] ed);
    vec_t v;
    v.mode = mode; v.sel = sel; v.valid = valid; v.rdy = rdy;
    v.expReady = er; v.expValid = ev; v.expChan = SW'(ec); v.expData = ed;
    return v;
  endfunction

  task automatic drive(input logic mode, input logic [SW-1:0] sel,
                       input logic [NCH-1:0] valid, input logic rdy);
    modeIn  = mode;
    selIn   = sel;
    validIn = valid;
    readyIn = rdy;
  endtask

  task automatic runVec(input vec_t v, input string tag);
    drive(v.mode, v.sel, v.valid, v.rdy);
    #2;
    check({tag, " ready"}, 64'(readyOut), 64'(v.expReady));
    @(posedge clk);
    #1;
    check({tag, " valid"}, 64'(validOut), 64'(v.expValid));
    check({tag, " chan"},  64'(chanOut),  64'(v.expChan));
    check({tag, " data"},  64'(dataOut),  64'(v.expData));
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mValid = 1'b0; mData = '0; mChan = 0; mPtr = NCH - 1;
  endtask

  // Spec-level grant: fixed candidate with fallback, or the first requester
  // when walking the channels after ptr in circular order.
  function automatic int refGrant(input logic mode, input int sel,
                                  input logic [NCH-1:0] valid, input int ptr);
    int order[$];
    if (mode == 1'b0) begin
      int c;
      c = (sel < NCH) ? sel : 0;
      return valid[c] ? c : -1;
    end
    for (int off = 1; off <= NCH; off++) order.push_back((ptr + off) % NCH);
    foreach (order[i]) if (valid[order[i]]) return order[i];
    return -1;
  endfunction

  task automatic randStep(input int n);
    logic           mode;
    logic [SW-1:0]  sel;
    logic [NCH-1:0] valid;
    logic           rdy;
    logic [NCH-1:0] expReady;
    int             g;
    logic           loadEn;
    string          tag;
    mode  = 1'($urandom_range(0, 1));
    sel   = SW'($urandom_range(0, 15));
    valid = NCH'($urandom);
    if ($urandom_range(0, 3) == 0) valid = '0;
    rdy   = ($urandom_range(0, 3) != 0);
    for (int k = 0; k < NCH; k++) chData[k] = $urandom;
    drive(mode, sel, valid, rdy);
    g        = refGrant(mode, int'(sel), valid, mPtr);
    loadEn   = !mValid || rdy;
    expReady = (loadEn && g >= 0) ? (NCH'(1) << g) : '0;
    tag      = $sformatf("rand%0d", n);
    #2;
    check({tag, " ready"}, 64'(readyOut), 64'(expReady));
    @(posedge clk);
    if (loadEn) begin
      if (g >= 0) begin
        mValid = 1'b1;
        mData  = chData[g];
        mChan  = g;
        if (mode) mPtr = g;
      end else begin
        mValid = 1'b0;
      end
    end
    #1;
    check({tag, " valid"}, 64'(validOut), 64'(mValid));
    if (mValid) begin
      check({tag, " chan"}, 64'(chanOut), 64'(mChan));
      check({tag, " data"}, 64'(dataOut), 64'(mData));
    end
  endtask

  initial begin
    for (int k = 0; k < NCH; k++) chData[k] = dirData(k);

    // Directed table; expectations follow the arbitration history in order.
    vecs.push_back(mk(1'b0, 4'd3, 8'h08, 1'b1, 8'h08, 1'b1, 3, 32'hDEAD_BEEF));
    vecs.push_back(mk(1'b0, 4'hA, 8'h01, 1'b1, 8'h01, 1'b1, 0, 32'h0000_0011));
    vecs.push_back(mk(1'b0, 4'd5, 8'h00, 1'b1, 8'h00, 1'b0, 0, 32'h0000_0011));
    for (int i = 0; i < 10; i++)
      vecs.push_back(mk(1'b1, 4'd0, 8'hFF, 1'b1, 8'(1) << (i % 8), 1'b1, i % 8, dirData(i % 8)));
    begin
      int skipSeq[4] = '{2, 5, 7, 2};
      for (int i = 0; i < 4; i++)
        vecs.push_back(mk(1'b1, 4'd0, 8'b1010_0100, 1'b1, 8'(1) << skipSeq[i], 1'b1,
                          skipSeq[i], dirData(skipSeq[i])));
    end
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(1'b1, 4'd0, 8'hFF, 1'b0, 8'h00, 1'b1, 2, dirData(2)));
    vecs.push_back(mk(1'b1, 4'd0, 8'hFF, 1'b1, 8'h08, 1'b1, 3, dirData(3)));
    vecs.push_back(mk(1'b1, 4'd0, 8'hFF, 1'b1, 8'h10, 1'b1, 4, dirData(4)));
    vecs.push_back(mk(1'b0, 4'd1, 8'hFD, 1'b1, 8'h00, 1'b0, 4, dirData(4)));
    vecs.push_back(mk(1'b1, 4'd0, 8'hFF, 1'b1, 8'h20, 1'b1, 5, dirData(5)));

    doReset();
    check("reset valid", 64'(validOut), 64'(0));
    check("reset data",  64'(dataOut),  64'(0));
    check("reset chan",  64'(chanOut),  64'(0));
    check("reset state", 64'(stateDbg), 64'(0));
    check("reset ready", 64'(readyOut), 64'(0));

    foreach (vecs[i]) runVec(vecs[i], $sformatf("vec%0d", i));

    // Async reset while a word is held under stall.
    runVec(mk(1'b1, 4'd0, 8'hFF, 1'b0, 8'h00, 1'b1, 5, dirData(5)), "prestall");
    #2;
    rst_n = 1'b0;
    #1;
    check("areset valid", 64'(validOut), 64'(0));
    check("areset data",  64'(dataOut),  64'(0));
    check("areset chan",  64'(chanOut),  64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    runVec(mk(1'b1, 4'd0, 8'hFF, 1'b1, 8'h01, 1'b1, 0, dirData(0)), "postrst0");
    runVec(mk(1'b1, 4'd0, 8'hFF, 1'b1, 8'h02, 1'b1, 1, dirData(1)), "postrst1");

    // Randomized traffic against the reference model.
    doReset();
    for (int n = 0; n < 400; n++) randStep(n);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
